// File: rtl/divi_vl.sv
// Signed restoring divider, one quotient bit per clock on magnitudes, truncating quotient/remainder, flags divide-by-zero.
// Latency: 34 clocks from start to valid (2 on divide-by-zero); DIV_EARLY_TERM_EN skips the dividend's leading zeros.
// Backpressure: none; start is ignored while busy, and start in the valid cycle is accepted.
module divi_vl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dvdnd,
   input  logic [WIDTH-1:0] dvsor,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] remd,
   output logic             valid,
   output logic             busy,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] dvdnd_l;
   logic [CW-1:0]    cnt;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] abs_dvdnd;
   logic [WIDTH-1:0] abs_dvsor;
   logic [WIDTH-1:0] dvd_init;
   logic [CW-1:0]    steps;
   logic [WIDTH-1:0] rem_sh;
   logic [WIDTH:0]   trial;

   assign abs_dvdnd = dvdnd[WIDTH-1] ? -dvdnd : dvdnd;
   assign abs_dvsor = dvsor[WIDTH-1] ? -dvsor : dvsor;

`ifdef DIV_EARLY_TERM_EN
   logic [CW-1:0] lz;

   always_comb begin
      lz = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (abs_dvdnd[i]) lz = CW'(WIDTH - 1 - i);
      end
   end

   assign dvd_init = abs_dvdnd << lz;
   assign steps    = (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
`else
   assign dvd_init = abs_dvdnd;
   assign steps    = CW'(WIDTH);
`endif

   // dvd doubles as the quotient register: dividend bits leave at the top while quotient bits enter at the bottom.
   assign rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
   assign trial  = {1'b0, rem_sh} - {1'b0, dvs};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         quot    <= '0;
         remd    <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         dbz     <= 1'b0;
         rem     <= '0;
         dvd     <= '0;
         dvs     <= '0;
         dvdnd_l <= '0;
         cnt     <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd     <= dvd_init;
                  dvs     <= abs_dvsor;
                  dvdnd_l <= dvdnd;
                  sign_q  <= dvdnd[WIDTH-1] ^ dvsor[WIDTH-1];
                  sign_r  <= dvdnd[WIDTH-1];
                  rem     <= '0;
                  cnt     <= steps;
                  busy    <= 1'b1;
                  state   <= (dvsor == '0) ? SIGN : CALC;
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh;
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= SIGN;
            end
            SIGN: begin
               if (dvs == '0) begin
                  quot <= '1;
                  remd <= dvdnd_l;
                  dbz  <= 1'b1;
               end else begin
                  quot <= sign_q ? -dvd : dvd;
                  remd <= sign_r ? -rem : rem;
                  dbz  <= 1'b0;
               end
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
